// File: rtl/nr_beamformer.sv
// Single-branch beamforming weight stage: 3-stage complex multiply by a fixed Q1.7 weight, round, then saturate or wrap.
// Define BEAMFORMER_SAT_EN to saturate the output to [-128, +127]; otherwise the result wraps (bits [14:7] of the rounded sum).
module nr_beamformer #(
  parameter logic signed [7:0] W_I = 8'sd64,
  parameter logic signed [7:0] W_Q = 8'sd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  output logic [15:0] data_out
);

  localparam logic signed [15:0] WIExt = {{8{W_I[7]}}, W_I};
  localparam logic signed [15:0] WQExt = {{8{W_Q[7]}}, W_Q};

  // Adds the half-LSB rounding constant and shifts back to Q1.7.
  function automatic logic [7:0] roundOut(input logic signed [16:0] sum);
    logic signed [16:0] shifted;
    shifted = (sum + 17'sd64) >>> 7;
`ifdef BEAMFORMER_SAT_EN
    if (shifted > 17'sd127) begin
      return 8'h7F;
    end else if (shifted < -17'sd128) begin
      return 8'h80;
    end else begin
      return shifted[7:0];
    end
`else
    return 8'(shifted);
`endif
  endfunction

  logic        [15:0] sample_q;
  logic signed [15:0] iExt, qExt;
  logic signed [15:0] iwi_d, qwq_d, iwq_d, qwi_d;
  logic signed [15:0] iwi_q, qwq_q, iwq_q, qwi_q;
  logic signed [16:0] reSum, imSum;
  logic        [15:0] out_d, out_q;

  assign iExt = {{8{sample_q[15]}}, sample_q[15:8]};
  assign qExt = {{8{sample_q[7]}},  sample_q[7:0]};

  always_comb begin
    iwi_d = iExt * WIExt;
    qwq_d = qExt * WQExt;
    iwq_d = iExt * WQExt;
    qwi_d = qExt * WIExt;
  end

  // 17 bits covers the worst-case sum of two 16-bit products plus the rounding constant.
  always_comb begin
    reSum = {iwi_q[15], iwi_q} - {qwq_q[15], qwq_q};
    imSum = {iwq_q[15], iwq_q} + {qwi_q[15], qwi_q};
    out_d = {roundOut(reSum), roundOut(imSum)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q <= '0;
      iwi_q    <= '0;
      qwq_q    <= '0;
      iwq_q    <= '0;
      qwi_q    <= '0;
      out_q    <= '0;
    end else begin
      sample_q <= data_in;
      iwi_q    <= iwi_d;
      qwq_q    <= qwq_d;
      iwq_q    <= iwq_d;
      qwi_q    <= qwi_d;
      out_q    <= out_d;
    end
  end

  assign data_out = out_q;

endmodule

// File: tb/tb_nr_beamformer.sv
// Directed bench for nr_beamformer: four instances with different steering weights share one stimulus stream.
// Expected outputs are hand-computed; overflow cases depend on whether BEAMFORMER_SAT_EN is defined.
module tb_nr_beamformer;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [15:0] outDef, outSat, outRot, outNeg;
  int          passCount;
  int          checkCount;

  nr_beamformer u_def (.clk(clk), .rst(rst), .data_in(data_in), .data_out(outDef));
  nr_beamformer #(.W_I(8'sd127), .W_Q(8'sd127)) u_sat (.clk(clk), .rst(rst), .data_in(data_in), .data_out(outSat));
  nr_beamformer #(.W_I(8'sd0), .W_Q(8'sd127)) u_rot (.clk(clk), .rst(rst), .data_in(data_in), .data_out(outRot));
  nr_beamformer #(.W_I(-8'sd128), .W_Q(8'sd0)) u_neg (.clk(clk), .rst(rst), .data_in(data_in), .data_out(outNeg));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [15:0] d);
    data_in = d;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  initial begin
    logic [15:0] expSat8080, expNeg8000;
`ifdef BEAMFORMER_SAT_EN
    expSat8080 = 16'h0080;
    expNeg8000 = 16'h7F00;
`else
    expSat8080 = 16'h0002;
    expNeg8000 = 16'h8000;
`endif
    passCount  = 0;
    checkCount = 0;
    rst = 1'b0;
    applyStimulus(16'h1234);

    // Reset held with a live input and running clock
    repeat (3) @(negedge clk);
    checkOutput("reset_def", outDef, 16'h0000);
    checkOutput("reset_sat", outSat, 16'h0000);
    checkOutput("reset_rot", outRot, 16'h0000);
    checkOutput("reset_neg", outNeg, 16'h0000);

    // Back-to-back stream with exact latency
    rst = 1'b1;
    applyStimulus(16'h1234);
    @(negedge clk); checkOutput("lat_e1", outDef, 16'h0000); applyStimulus(16'hABCD);
    @(negedge clk); checkOutput("lat_e2", outDef, 16'h0000); applyStimulus(16'h0000);
    @(negedge clk); checkOutput("s_1234", outDef, 16'h091A); applyStimulus(16'hFFFF);
    @(negedge clk); checkOutput("s_ABCD", outDef, 16'hD6E7); applyStimulus(16'h8080);
    @(negedge clk); checkOutput("s_0000", outDef, 16'h0000); applyStimulus(16'h4000);
    @(negedge clk); checkOutput("s_FFFF", outDef, 16'h0000); applyStimulus(16'h8000);
    @(negedge clk); checkOutput("def_8080", outDef, 16'hC0C0);
                    checkOutput("sat_8080", outSat, expSat8080);
    @(negedge clk); checkOutput("rot_4000", outRot, 16'h0040);
    @(negedge clk); checkOutput("neg_8000", outNeg, expNeg8000);

    // Asynchronous reset mid-stream, then confirm in-flight samples were discarded
    applyStimulus(16'h1234);
    repeat (3) @(negedge clk);
    checkOutput("pre_async", outDef, 16'h091A);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("async_rst", outDef, 16'h0000);
    @(negedge clk);
    applyStimulus(16'h0000);
    rst = 1'b1;
    @(negedge clk); checkOutput("flush_e1", outDef, 16'h0000);
    @(negedge clk); checkOutput("flush_e2", outDef, 16'h0000);
    @(negedge clk); checkOutput("flush_e3", outDef, 16'h0000);

    // Fresh sample after reset release
    applyStimulus(16'hABCD);
    repeat (3) @(negedge clk);
    checkOutput("post_ABCD", outDef, 16'hD6E7);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
